// File: rtl/byte_ram_pkg.sv
// byte_ram_pkg: shared state encoding and address-offset helper for byte_ram
package byte_ram_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  function automatic int ofs_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction
endpackage

// File: rtl/byte_ram_array.sv
// byte_ram_array: word storage with per-byte write enable and registered read
module byte_ram_array #(
  parameter int DATA_W = 32,
  parameter int AW = 14
) (
  input  logic              clock,
  input  logic [DATA_W/8-1:0] we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [1 << AW];
  always_ff @(posedge clock) begin
    for (int i = 0; i < DATA_W / 8; i++) if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/byte_ram.sv
// byte_ram: byte-enabled RAM with clear-on-reset, misalignment errors and pipelined reads
module byte_ram
  import byte_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int OUT_REG = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                err_sticky,
  output logic                init_done
);
  localparam int OFS = ofs_w(DATA_W);
  localparam int AW = ADDR_W - OFS;
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'((1 << OFS) - 1);
  state_t st;
  logic [AW-1:0] clr_idx, addr;
  logic [NB-1:0] we;
  logic [DATA_W-1:0] wdata, rdata, s1_data;
  logic acc, mis, clearing, v1, e1;
  assign clearing = st == CLEAR;
  assign req_ready = st == READY;
  assign init_done = req_ready;
  assign acc = req_valid & req_ready & resetn;
  assign mis = |(req_addr & MASK);
  always_comb begin
    addr = clearing ? clr_idx : AW'(req_addr >> OFS);
    we = clearing ? '1 : (acc & req_write & ~mis) ? req_be : '0;
    wdata = clearing ? '0 : req_wdata;
  end
  byte_ram_array #(.DATA_W(DATA_W), .AW(AW)) u_array (
    .clock(clock),
    .we(we),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata)
  );
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
      clr_idx <= '0;
      v1 <= 1'b0;
      e1 <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (clearing) begin
        clr_idx <= clr_idx + 1'b1;
        if (&clr_idx) st <= READY;
      end
      v1 <= acc & ~req_write;
      e1 <= acc & ~req_write & mis;
      err_sticky <= err_sticky | (acc & mis);
    end
  end
  assign s1_data = e1 ? '0 : rdata;
  generate
    if (OUT_REG != 0) begin : g_reg
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          rsp_valid <= 1'b0;
          rsp_err <= 1'b0;
          rsp_rdata <= '0;
        end else begin
          rsp_valid <= v1;
          rsp_err <= e1;
          if (v1) rsp_rdata <= s1_data;
        end
      end
    end else begin : g_comb
      logic [DATA_W-1:0] last;
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) last <= '0;
        else if (v1) last <= s1_data;
      end
      assign rsp_valid = v1;
      assign rsp_err = e1;
      assign rsp_rdata = v1 ? s1_data : last;
    end
  endgenerate
endmodule

// File: tb/tb_byte_ram.sv
// tb_byte_ram: scoreboard bench driving OUT_REG=0 and OUT_REG=1 instances in lockstep
module tb_byte_ram;
  typedef struct {
    int cyc;
    logic err;
    logic [31:0] data;
  } exp_t;
  logic clock = 1'b0;
  logic resetn, req_valid, req_write;
  logic [3:0] req_be;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic r0_ready, r0_valid, r0_err, r0_sticky, r0_done;
  logic r1_ready, r1_valid, r1_err, r1_sticky, r1_done;
  logic [31:0] r0_rdata, r1_rdata;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  byte_ram #(.OUT_REG(0)) d0 (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(r0_ready),
    .req_write(req_write), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r0_valid), .rsp_rdata(r0_rdata), .rsp_err(r0_err),
    .err_sticky(r0_sticky), .init_done(r0_done)
  );
  byte_ram #(.OUT_REG(1)) d1 (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(r1_ready),
    .req_write(req_write), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r1_valid), .rsp_rdata(r1_rdata), .rsp_err(r1_err),
    .err_sticky(r1_sticky), .init_done(r1_done)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic req(input logic w, input logic [3:0] be, input logic [15:0] a,
                     input logic [31:0] d, input logic ee, input logic [31:0] ed);
    req_valid = 1'b1;
    req_write = w;
    req_be = be;
    req_addr = a;
    req_wdata = d;
    @(posedge clock);
    #1;
    if (!w) begin
      q0.push_back('{cyc - 1, ee, ed});
      q1.push_back('{cyc - 1, ee, ed});
    end
  endtask
  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask
  task automatic wait_ready();
    int n;
    n = 0;
    while (!r0_done && n < 20000) begin
      @(negedge clock);
      n++;
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clock);
    chk("drain q0", 64'(q0.size()), 64'd0);
    chk("drain q1", 64'(q1.size()), 64'd0);
  endtask
  initial begin
    int rel;
    int n;
    exp_t e;
    resetn = 1'b0;
    idle();
    req_be = '0;
    req_addr = '0;
    req_wdata = '0;
    fork
      forever begin
        @(negedge clock);
        if (r0_valid) begin
          if (q0.size() == 0) begin
            n_bad++;
            $display("FAIL d0 unexpected rsp_valid at cycle %0d: got 1 expected 0", cyc);
          end else begin
            e = q0.pop_front();
            chk("d0 latency", 64'(cyc), 64'(e.cyc + 1));
            chk("d0 rsp_err", 64'(r0_err), 64'(e.err));
            chk("d0 rsp_rdata", 64'(r0_rdata), 64'(e.data));
          end
        end
      end
      forever begin
        @(negedge clock);
        if (r1_valid) begin
          if (q1.size() == 0) begin
            n_bad++;
            $display("FAIL d1 unexpected rsp_valid at cycle %0d: got 1 expected 0", cyc);
          end else begin
            exp_t f;
            f = q1.pop_front();
            chk("d1 latency", 64'(cyc), 64'(f.cyc + 2));
            chk("d1 rsp_err", 64'(r1_err), 64'(f.err));
            chk("d1 rsp_rdata", 64'(r1_rdata), 64'(f.data));
          end
        end
      end
    join_none
    repeat (3) @(negedge clock);
    chk("reset rsp_valid", 64'({r0_valid, r1_valid}), 64'd0);
    chk("reset rsp_err", 64'({r0_err, r1_err}), 64'd0);
    chk("reset rsp_rdata d0", 64'(r0_rdata), 64'd0);
    chk("reset rsp_rdata d1", 64'(r1_rdata), 64'd0);
    chk("reset err_sticky", 64'({r0_sticky, r1_sticky}), 64'd0);
    chk("reset init_done", 64'({r0_done, r1_done}), 64'd0);
    chk("reset req_ready", 64'({r0_ready, r1_ready}), 64'd0);
    chk("reset clr_idx", 64'(d0.clr_idx), 64'd0);
    resetn = 1'b1;
    rel = cyc;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_be = 4'hF;
    req_addr = 16'h0020;
    req_wdata = 32'hDEADBEEF;
    repeat (10) @(negedge clock);
    idle();
    chk("clear req_ready", 64'(r0_ready), 64'd0);
    wait_ready();
    chk("init_done d0", 64'(r0_done), 64'd1);
    chk("init_done d1", 64'(r1_done), 64'd1);
    chk("clear cycles", 64'(cyc - rel), 64'd16384);
    req(1'b0, 4'h0, 16'h0000, 32'h0, 1'b0, 32'h0);
    req(1'b0, 4'h0, 16'hFFFC, 32'h0, 1'b0, 32'h0);
    req(1'b0, 4'h0, 16'h0020, 32'h0, 1'b0, 32'h0);
    req(1'b1, 4'hF, 16'h0010, 32'hAABBCCDD, 1'b0, 32'h0);
    req(1'b1, 4'h5, 16'h0010, 32'h11223344, 1'b0, 32'h0);
    req(1'b0, 4'h0, 16'h0010, 32'h0, 1'b0, 32'hAA22CC44);
    req(1'b1, 4'h0, 16'h0010, 32'h55555555, 1'b0, 32'h0);
    req(1'b1, 4'hF, 16'h0100, 32'h01020304, 1'b0, 32'h0);
    req(1'b1, 4'hF, 16'h0104, 32'h11121314, 1'b0, 32'h0);
    req(1'b1, 4'hF, 16'h0108, 32'h21222324, 1'b0, 32'h0);
    req(1'b1, 4'hF, 16'h010C, 32'h31323334, 1'b0, 32'h0);
    req(1'b0, 4'h0, 16'h0100, 32'h0, 1'b0, 32'h01020304);
    req(1'b0, 4'h0, 16'h0104, 32'h0, 1'b0, 32'h11121314);
    req(1'b0, 4'h0, 16'h0108, 32'h0, 1'b0, 32'h21222324);
    req(1'b0, 4'h0, 16'h010C, 32'h0, 1'b0, 32'h31323334);
    idle();
    drain();
    chk("err_sticky before misalign", 64'(r0_sticky), 64'd0);
    req(1'b1, 4'hF, 16'h0013, 32'hFFFFFFFF, 1'b0, 32'h0);
    idle();
    @(negedge clock);
    chk("err_sticky after misaligned write d0", 64'(r0_sticky), 64'd1);
    chk("err_sticky after misaligned write d1", 64'(r1_sticky), 64'd1);
    req(1'b0, 4'h0, 16'h0010, 32'h0, 1'b0, 32'hAA22CC44);
    req(1'b0, 4'h0, 16'h0006, 32'h0, 1'b1, 32'h0);
    req(1'b0, 4'h0, 16'h0010, 32'h0, 1'b0, 32'hAA22CC44);
    idle();
    drain();
    repeat (3) @(negedge clock);
    chk("hold rsp_rdata d0", 64'(r0_rdata), 64'hAA22CC44);
    chk("hold rsp_rdata d1", 64'(r1_rdata), 64'hAA22CC44);
    chk("err_sticky stays", 64'(r0_sticky), 64'd1);
    req(1'b0, 4'h0, 16'h0010, 32'h0, 1'b0, 32'h0);
    q0.delete();
    q1.delete();
    resetn = 1'b0;
    idle();
    @(negedge clock);
    chk("flush rsp_valid", 64'({r0_valid, r1_valid}), 64'd0);
    chk("flush err_sticky", 64'({r0_sticky, r1_sticky}), 64'd0);
    chk("flush init_done", 64'(r0_done), 64'd0);
    resetn = 1'b1;
    n = 0;
    while (d0.clr_idx != 14'd100 && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("clr_idx reached 100", 64'(d0.clr_idx), 64'd100);
    resetn = 1'b0;
    #1;
    chk("clr_idx in reset", 64'(d0.clr_idx), 64'd0);
    @(negedge clock);
    resetn = 1'b1;
    rel = cyc;
    @(negedge clock);
    chk("clr_idx restart", 64'(d0.clr_idx), 64'd1);
    wait_ready();
    chk("init_done after restart", 64'(r0_done), 64'd1);
    chk("restart clear cycles", 64'(cyc - rel), 64'd16384);
    req(1'b0, 4'h0, 16'h0010, 32'h0, 1'b0, 32'h0);
    req(1'b0, 4'h0, 16'h0104, 32'h0, 1'b0, 32'h0);
    idle();
    drain();
    repeat (5) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
